alarm_bank: RTL and testbench
=============================

// Module: alarm_bank
// PURPOSE
//  Multi-channel successor to the single-compare alarm: NUM_CH independent alarm channels compare a
//  shared free-running counter_i against per-channel compare registers. Each channel is one-shot or
//  periodic (auto-reload by adding a period), latches a pending flag until acknowledged, and all
//  channels feed one OR-ed interrupt. Sits beside the system counter and feeds the interrupt controller.
// PARAMETERS
//  CNT_W   32  width of counter_i, compare and period registers
//  NUM_CH  4   number of alarm channels (1..16); CH_W = max(1,$clog2(NUM_CH))
// PORTS
//  clk_i          in   1       clock
//  rst_an_i       in   1       reset, asynchronous, active-low
//  rst_i          in   1       synchronous reset, active-high; same effect as rst_an_i
//  counter_i      in   CNT_W   shared time base
//  cfg_we_i       in   1       config write strobe, one channel per cycle
//  cfg_ch_i       in   CH_W    channel index for write
//  cfg_en_i       in   1       channel enable value written
//  cfg_mode_i     in   1       0 = one-shot, 1 = periodic
//  cfg_alarm_i    in   CNT_W   compare value written
//  cfg_period_i   in   CNT_W   reload increment (periodic mode)
//  ack_i          in   NUM_CH  per-channel pending clear, level-sampled
//  irq_mask_i     in   NUM_CH  1 = channel contributes to irq_o
//  alarm_pulse_o  out  NUM_CH  1-cycle pulse per match
//  alarm_pend_o   out  NUM_CH  sticky pending flags
//  irq_o          out  1       |(alarm_pend_o & irq_mask_i), registered
// BEHAVIOUR
//  - Reset (either): all outputs 0; all channels IDLE; compare/period/mode registers 0.
//  - Per-channel FSM: IDLE (en=0) -> ARMED on write with cfg_en_i=1; ARMED -> IDLE on write with en=0.
//    ARMED + match (counter_i == compare, sampled cycle N): alarm_pulse_o=1 and pend=1 in cycle N+1.
//    One-shot: ARMED -> DONE after match; DONE ignores further matches; DONE -> ARMED/IDLE on rewrite.
//    Periodic: stays ARMED; compare <= compare + period, modulo 2^CNT_W (wrap, no saturation).
//  - Periodic with period==0: treated as one-shot (no reload, goes to DONE).
//  - irq_o is registered from pend: asserts cycle N+2 after the match sample.
//  - ack_i[k]=1 clears pend[k] next cycle. Match on ch k and ack_i[k] in same cycle: set wins, pend stays 1.
//  - cfg_we_i to ch k in the cycle ch k matches: write wins; no pulse, no reload, pend unchanged.
//  - Writes to cfg_ch_i >= NUM_CH are ignored.
//  - Rewriting an ARMED channel does not clear its pend flag; only ack_i or reset clears it.
//  - Counter wrap is not special: match is pure equality; compare values behind counter_i wait a full wrap.
//  - Channels are fully independent; simultaneous matches on several channels all pulse in the same cycle.
//  - rst_i or rst_an_i mid-operation: immediate return to reset state; in-flight pulses are dropped.
// CONFIGURATION
//  ALARM_BANK_OVERRUN_EN defined: adds output ovr_o[NUM_CH] (reset 0) and per-channel 4-bit
//    overrun counter ovr_cnt_o[4*NUM_CH] (reset 0). A match while pend[k] is already 1 (and not acked
//    that cycle) sets ovr_o[k] sticky and increments ovr_cnt[k], saturating at 15. ack_i[k] clears both.
//  Not defined: ports absent; a repeated match while pending is silently merged into pend.
// TESTING
//  1 One-shot: ch0 alarm=100, en=1; counter 95..110 -> one pulse cycle after counter=100, pend0=1,
//    irq_o one cycle later (mask0=1); no pulse at a second pass of 100; ack0 -> pend0=0, irq_o=0.
//  2 Periodic: ch1 alarm=10, period=5; counter 0..40 -> pulses after 10,15,20,..,40; wrap case
//    CNT_W=8, alarm=250, period=10 -> next compare 4, pulse after counter wraps to 4.
//  3 Collisions: ack1 same cycle as ch1 match -> pend1 stays 1; cfg write to ch2 in its match
//    cycle -> no pulse, new compare value taken.
//  4 Multi-channel: ch0..3 all alarm=50 -> all 4 pulses same cycle; mask=4'b0100 -> irq_o follows pend2 only.
//  5 Reset: assert rst_i, and separately rst_an_i, mid-periodic run -> all outputs 0 next edge/immediately,
//    channels IDLE, no pulses until reconfigured; write to cfg_ch_i=NUM_CH -> no state change.
//  6 ALARM_BANK_OVERRUN_EN: ch3 period=4, never ack for 20 matches -> ovr_o[3]=1, ovr_cnt=15; ack3 clears.

Source files
------------

// File: rtl/alarm_bank_if.sv
// Configuration write bus for alarm_bank: one channel written per cycle.
// The master drives the strobe and fields; alarm_bank is the slave.
interface alarm_bank_if #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_we_i;
  logic [CH_W-1:0]  cfg_ch_i;
  logic             cfg_en_i;
  logic             cfg_mode_i;
  logic [CNT_W-1:0] cfg_alarm_i;
  logic [CNT_W-1:0] cfg_period_i;

  modport master (
    output cfg_we_i, cfg_ch_i, cfg_en_i,
    output cfg_mode_i, cfg_alarm_i, cfg_period_i
  );

  modport slave (
    input cfg_we_i, cfg_ch_i, cfg_en_i,
    input cfg_mode_i, cfg_alarm_i, cfg_period_i
  );
endinterface

// File: rtl/alarm_bank.sv
// NUM_CH one-shot/periodic compare alarms on a shared counter, OR-ed irq.
// Define ALARM_BANK_OVERRUN_EN to add per-channel overrun flag/counter.
module alarm_bank #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rst_an_i,
  input  logic              rst_i,
  input  logic [CNT_W-1:0]  counter_i,
  alarm_bank_if.slave       cfg,
  input  logic [NUM_CH-1:0] ack_i,
  input  logic [NUM_CH-1:0] irq_mask_i,
  output logic [NUM_CH-1:0] alarm_pulse_o,
  output logic [NUM_CH-1:0] alarm_pend_o,
  output logic              irq_o
`ifdef ALARM_BANK_OVERRUN_EN
  ,
  output logic [NUM_CH-1:0]   ovr_o,
  output logic [4*NUM_CH-1:0] ovr_cnt_o
`endif
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } st_e;

  st_e              state_q [NUM_CH];
  st_e              state_d [NUM_CH];
  logic [CNT_W-1:0] cmp_q   [NUM_CH];
  logic [CNT_W-1:0] cmp_d   [NUM_CH];
  logic [CNT_W-1:0] per_q   [NUM_CH];
  logic [CNT_W-1:0] per_d   [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] wr, hit;

  logic [NUM_CH-1:0] pulse_d, pend_d;
  logic              irq_d;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= IDLE;
        cmp_q[k]   <= '0;
        per_q[k]   <= '0;
      end
      mode_q <= '0;
    end else if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= IDLE;
        cmp_q[k]   <= '0;
        per_q[k]   <= '0;
      end
      mode_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        cmp_q[k]   <= cmp_d[k];
        per_q[k]   <= per_d[k];
      end
      mode_q <= mode_d;
    end
  end

  // A write to a channel pre-empts its match in the same cycle.
  always_comb begin
    mode_d = mode_q;
    wr     = '0;
    hit    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      cmp_d[k]   = cmp_q[k];
      per_d[k]   = per_q[k];
      wr[k]  = cfg.cfg_we_i && (cfg.cfg_ch_i == CH_W'(k));
      hit[k] = !wr[k] && (state_q[k] == ARMED) &&
               (counter_i == cmp_q[k]);
      unique case (1'b1)
        wr[k]: begin
          state_d[k] = cfg.cfg_en_i ? ARMED : IDLE;
          cmp_d[k]   = cfg.cfg_alarm_i;
          per_d[k]   = cfg.cfg_period_i;
          mode_d[k]  = cfg.cfg_mode_i;
        end
        hit[k]: begin
          if (mode_q[k] && (per_q[k] != '0)) begin
            cmp_d[k] = cmp_q[k] + per_q[k];
          end else begin
            state_d[k] = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pulse_d = hit;
    pend_d  = hit | (alarm_pend_o & ~ack_i);
    irq_d   = |(alarm_pend_o & irq_mask_i);
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      alarm_pulse_o <= '0;
      alarm_pend_o  <= '0;
      irq_o         <= 1'b0;
    end else if (rst_i) begin
      alarm_pulse_o <= '0;
      alarm_pend_o  <= '0;
      irq_o         <= 1'b0;
    end else begin
      alarm_pulse_o <= pulse_d;
      alarm_pend_o  <= pend_d;
      irq_o         <= irq_d;
    end
  end

`ifdef ALARM_BANK_OVERRUN_EN
  logic [NUM_CH-1:0]   ovr_d;
  logic [4*NUM_CH-1:0] ovr_cnt_d;
  logic [NUM_CH-1:0]   ovr_set;

  always_comb begin
    ovr_d     = ovr_o;
    ovr_cnt_d = ovr_cnt_o;
    ovr_set   = hit & alarm_pend_o & ~ack_i;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ack_i[k]) begin
        ovr_d[k]         = 1'b0;
        ovr_cnt_d[4*k+:4] = 4'd0;
      end else if (ovr_set[k]) begin
        ovr_d[k] = 1'b1;
        if (ovr_cnt_o[4*k+:4] != 4'hf) begin
          ovr_cnt_d[4*k+:4] = ovr_cnt_o[4*k+:4] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      ovr_o     <= '0;
      ovr_cnt_o <= '0;
    end else if (rst_i) begin
      ovr_o     <= '0;
      ovr_cnt_o <= '0;
    end else begin
      ovr_o     <= ovr_d;
      ovr_cnt_o <= ovr_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_alarm_bank.sv
// Directed + random bench for alarm_bank (CNT_W=8, NUM_CH=3).
// Expected outputs come from a per-channel behavioural model.
module tb_alarm_bank;
  localparam int W = 8;
  localparam int N = 3;

  logic clk_i = 1'b0;
  logic rst_an_i = 1'b0;
  logic rst_i = 1'b0;
  logic [W-1:0] cnt = '0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] pulse, pend;
  logic irq;
`ifdef ALARM_BANK_OVERRUN_EN
  logic [N-1:0]   ovr;
  logic [4*N-1:0] ovr_cnt;
`endif

  alarm_bank_if #(.CNT_W(W), .NUM_CH(N)) bus ();

  alarm_bank #(.CNT_W(W), .NUM_CH(N)) dut (
    .clk_i         (clk_i),
    .rst_an_i      (rst_an_i),
    .rst_i         (rst_i),
    .counter_i     (cnt),
    .cfg           (bus.slave),
    .ack_i         (ack),
    .irq_mask_i    (mask),
    .alarm_pulse_o (pulse),
    .alarm_pend_o  (pend),
    .irq_o         (irq)
`ifdef ALARM_BANK_OVERRUN_EN
    ,
    .ovr_o         (ovr),
    .ovr_cnt_o     (ovr_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail = 0;

  // model state
  bit         live [N];
  logic [W-1:0] mcmp [N];
  logic [W-1:0] mper [N];
  bit         mper_mode [N];
  logic [N-1:0] e_pulse, e_pend;
  logic         e_irq;
  logic [N-1:0] e_ovr;
  int           e_ocnt [N];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      live[k] = 0; mcmp[k] = '0; mper[k] = '0;
      mper_mode[k] = 0; e_ocnt[k] = 0;
    end
    e_pulse = '0; e_pend = '0; e_irq = 0; e_ovr = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] np;
    bit wk, h;
    if (!rst_an_i || rst_i) begin
      model_reset();
      return;
    end
    e_irq = |(e_pend & mask);
    np = '0;
    for (int k = 0; k < N; k++) begin
      wk = bus.cfg_we_i && (int'(bus.cfg_ch_i) == k);
      h  = live[k] && (cnt == mcmp[k]) && !wk;
      e_pulse[k] = h;
      np[k] = h || (e_pend[k] && !ack[k]);
      if (ack[k]) begin
        e_ovr[k] = 0; e_ocnt[k] = 0;
      end else if (h && e_pend[k]) begin
        e_ovr[k] = 1;
        e_ocnt[k] = (e_ocnt[k] < 15) ? e_ocnt[k] + 1 : 15;
      end
      if (wk) begin
        live[k] = bus.cfg_en_i;
        mcmp[k] = bus.cfg_alarm_i;
        mper[k] = bus.cfg_period_i;
        mper_mode[k] = bus.cfg_mode_i;
      end else if (h) begin
        if (mper_mode[k] && mper[k] != 0)
          mcmp[k] = W'((int'(mcmp[k]) + int'(mper[k])) % 256);
        else
          live[k] = 0;
      end
    end
    e_pend = np;
  endtask

  task automatic compare();
    logic [4*N-1:0] oc;
    chk("pulse", 32'(pulse), 32'(e_pulse));
    chk("pend", 32'(pend), 32'(e_pend));
    chk("irq", 32'(irq), 32'(e_irq));
`ifdef ALARM_BANK_OVERRUN_EN
    for (int k = 0; k < N; k++) oc[4*k+:4] = 4'(e_ocnt[k]);
    chk("ovr", 32'(ovr), 32'(e_ovr));
    chk("ovr_cnt", 32'(ovr_cnt), 32'(oc));
`else
    oc = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    compare();
    bus.cfg_we_i = 1'b0;
    ack = '0;
    cnt = cnt + 1'b1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(int ch, bit en, bit md, int al, int pr);
    bus.cfg_we_i     = 1'b1;
    bus.cfg_ch_i     = 2'(ch);
    bus.cfg_en_i     = en;
    bus.cfg_mode_i   = md;
    bus.cfg_alarm_i  = W'(al);
    bus.cfg_period_i = W'(pr);
  endtask

  initial begin
    int np;
    bus.cfg_we_i = 1'b0; bus.cfg_ch_i = '0; bus.cfg_en_i = 1'b0;
    bus.cfg_mode_i = 1'b0; bus.cfg_alarm_i = '0; bus.cfg_period_i = '0;
    model_reset();
    run(2);
    chk("rst_pend", 32'(pend), 32'h0);
    rst_an_i = 1'b1;

    // one-shot ch0 at 100, passed twice
    mask = 3'b001;
    cnt = 8'd90;
    wr(0, 1, 0, 100, 0);
    run(21);
    chk("os_pend", 32'(pend[0]), 32'h1);
    chk("os_irq", 32'(irq), 32'h1);
    cnt = 8'd95;
    run(10);
    ack = 3'b001;
    run(3);
    chk("os_ack_irq", 32'(irq), 32'h0);

    // periodic ch1 10+5k, then 8-bit wrap 250 -> 4
    cnt = 8'd0;
    wr(1, 1, 1, 10, 5);
    run(42);
    cnt = 8'd240;
    wr(1, 1, 1, 250, 10);
    run(24);
    wr(1, 0, 0, 0, 0);
    ack = 3'b111;
    run(2);

    // ack colliding with match: pend stays set
    cnt = 8'd20;
    wr(1, 1, 0, 23, 0);
    run(3);
    ack = 3'b010;
    tick();
    chk("ack_coll", 32'(pend[1]), 32'h1);
    // write colliding with match: new compare wins
    cnt = 8'd30;
    wr(2, 1, 0, 40, 0);
    run(10);
    wr(2, 1, 0, 45, 0);
    tick();
    chk("wr_coll", 32'(pulse[2]), 32'h0);
    run(8);
    ack = 3'b111;
    run(2);

    // all channels at 50, irq from ch2 only
    mask = 3'b100;
    cnt = 8'd40;
    for (int k = 0; k < N; k++) begin
      wr(k, 1, 0, 50, 0);
      tick();
    end
    run(8);
    chk("multi_pulse", 32'(pulse), 32'h7);
    run(2);
    ack = 3'b100;
    run(3);
    chk("multi_irq", 32'(irq), 32'h0);

    // sync reset mid periodic run
    ack = 3'b111;
    mask = 3'b111;
    wr(0, 1, 1, int'(cnt) + 3, 3);
    run(10);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("srst_pend", 32'(pend), 32'h0);
    run(20);
    // async reset mid periodic run
    wr(0, 1, 1, int'(cnt) + 2, 2);
    run(7);
    rst_an_i = 1'b0;
    #1;
    chk("arst_pulse", 32'(pulse), 32'h0);
    chk("arst_pend", 32'(pend), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    tick();
    rst_an_i = 1'b1;
    run(20);
    // out-of-range channel write
    wr(3, 1, 0, int'(cnt) + 2, 0);
    run(6);
    chk("bad_ch", 32'(pend), 32'h0);

    // overrun: ch2 every 4 counts, never acked
    wr(2, 1, 1, int'(cnt) + 1, 4);
    run(90);
`ifdef ALARM_BANK_OVERRUN_EN
    chk("ovr_set", 32'(ovr[2]), 32'h1);
    chk("ovr_sat", 32'(ovr_cnt[11:8]), 32'hf);
`endif
    wr(2, 0, 0, 0, 0);
    ack = 3'b100;
    run(2);

    // random phase
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) begin
        np = $urandom_range(7);
        wr($urandom_range(3), $urandom_range(4) != 0,
           $urandom_range(1), int'(cnt) + $urandom_range(15), np);
      end
      ack = ($urandom_range(5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(15) == 0) mask = N'($urandom);
      if ($urandom_range(40) == 0) cnt = W'($urandom);
      rst_i = ($urandom_range(150) == 0);
      tick();
      rst_i = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
